// File: rtl/stepper_ramp_ctrl_pkg.sv
// Shared definitions for the stepper ramp controller.
// Holds the sequencer state type, default timing constants (50 MHz clock,
// A4988 at 1/16 microstep) and a small width helper.
package stepper_ramp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCEL,
    CRUISE,
    DECEL
  } state_t;

  localparam int unsigned DEF_STEP_W       = 24;
  localparam int unsigned DEF_PERIOD_W     = 16;
  localparam int unsigned DEF_START_PERIOD = 62500;  // 800 Hz
  localparam int unsigned DEF_MIN_PERIOD   = 15625;  // 3200 Hz, 60 RPM
  localparam int unsigned DEF_RAMP_DELTA   = 250;
  localparam int unsigned DEF_PULSE_W      = 100;    // 2 us STEP high time
  localparam int unsigned DEF_DIR_SETUP    = 10;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stepper_ramp_ctrl_timer.sv
// step_pulse_timer: per-step period counter for the stepper sequencer.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   run         sequencer is in a stepping state
//   halt        stop at this edge (final step end), no new step begins
//   period      length of the current step in clk cycles
//   step_out    registered STEP output, high for the first PULSE_W cycles
//   step_start  strobe: a step begins (step_out rises) at the next edge
//   step_end    strobe: the current step's last cycle
module step_pulse_timer #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned PULSE_W  = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                halt,
  input  logic [PERIOD_W-1:0] period,
  output logic                step_out,
  output logic                step_start,
  output logic                step_end
);

  localparam logic [PERIOD_W-1:0] PULSE_V = PERIOD_W'(PULSE_W);

  logic [PERIOD_W-1:0] timer;
  logic                active;

  assign step_end   = run && active && (timer == period - 1'b1);
  assign step_start = run && !halt && (!active || step_end);

  always_ff @(posedge clk) begin
    if (rst || halt || !run) begin
      timer    <= '0;
      active   <= 1'b0;
      step_out <= 1'b0;
    end else if (step_start) begin
      // Next step picks up whatever period the sequencer loads on this edge.
      timer    <= '0;
      active   <= 1'b1;
      step_out <= 1'b1;
    end else begin
      timer    <= timer + 1'b1;
      step_out <= (timer + 1'b1) < PULSE_V;
    end
  end

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// stepper_ramp_ctrl: trapezoidal-profile motion sequencer for an A4988.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  move command handshake
//   cmd_dir, cmd_steps   direction (1 = forward) and step count
//   abort                request a ramped stop
//   step_out, dir_out,   A4988 STEP / DIR / ENABLE (active low)
//   en_n_out
//   busy, done           move in progress / one-cycle completion pulse
//   pos                  signed absolute position in steps (wraps)
module stepper_ramp_ctrl
  import stepper_ramp_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W       = DEF_STEP_W,
  parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
  parameter int unsigned START_PERIOD = DEF_START_PERIOD,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned RAMP_DELTA   = DEF_RAMP_DELTA,
  parameter int unsigned PULSE_W      = DEF_PULSE_W,
  parameter int unsigned DIR_SETUP    = DEF_DIR_SETUP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               abort,
  output logic               step_out,
  output logic               dir_out,
  output logic               en_n_out,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] pos
);

  localparam int unsigned SETUP_W      = cnt_width(DIR_SETUP);
  localparam int unsigned SETUP_LAST_I = (DIR_SETUP > 0) ? DIR_SETUP - 1 : 0;
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_LAST_I);

  localparam logic [PERIOD_W-1:0] START_V = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_V   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   START_X = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0]   MIN_X   = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   DELTA_X = (PERIOD_W+1)'(RAMP_DELTA);

  state_t              state;
  logic [STEP_W-1:0]   remaining;
  logic [STEP_W-1:0]   accel_cnt;
  logic [PERIOD_W-1:0] period;
  logic [SETUP_W-1:0]  setup_cnt;
  logic                abort_lat;

  logic                run;
  logic                halt;
  logic                last_step;
  logic                abort_now;
  logic                step_start;
  logic                step_end;
  logic [STEP_W-1:0]   rem_dec;
  logic [STEP_W-1:0]   acc_inc;
  logic [STEP_W-1:0]   cap_ref;
  logic [STEP_W-1:0]   rem_next;
  logic [PERIOD_W:0]   per_ext;
  logic [PERIOD_W:0]   per_up_raw;
  logic [PERIOD_W-1:0] per_up;
  logic [PERIOD_W-1:0] per_dn;

  assign run       = state inside {ACCEL, CRUISE, DECEL};
  assign last_step = (remaining == STEP_W'(1));
  assign halt      = step_end && last_step;
  assign abort_now = abort_lat || abort;
  assign rem_dec   = remaining - 1'b1;
  assign acc_inc   = accel_cnt + 1'b1;

  always_comb begin
    // Ramp-down step count: ACCEL compares against the count including this step.
    cap_ref    = (state == ACCEL) ? acc_inc : accel_cnt;
    rem_next   = (abort_now && (rem_dec > cap_ref)) ? cap_ref : rem_dec;
    per_ext    = {1'b0, period};
    per_up_raw = per_ext + DELTA_X;
    per_up     = (per_up_raw >= START_X) ? START_V : per_up_raw[PERIOD_W-1:0];
    per_dn     = (per_ext <= MIN_X + DELTA_X) ? MIN_V : PERIOD_W'(per_ext - DELTA_X);
  end

  step_pulse_timer #(
    .PERIOD_W (PERIOD_W),
    .PULSE_W  (PULSE_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .halt       (halt),
    .period     (period),
    .step_out   (step_out),
    .step_start (step_start),
    .step_end   (step_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      dir_out   <= 1'b0;
      en_n_out  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pos       <= '0;
      remaining <= '0;
      accel_cnt <= '0;
      period    <= START_V;
      setup_cnt <= '0;
      abort_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          abort_lat <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            dir_out   <= cmd_dir;
            remaining <= cmd_steps;
            period    <= START_V;
            accel_cnt <= '0;
            setup_cnt <= '0;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state     <= SETUP;
              en_n_out  <= 1'b0;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end
        end

        SETUP: begin
          if (abort) begin
            state     <= IDLE;
            done      <= 1'b1;
            busy      <= 1'b0;
            en_n_out  <= 1'b1;
            cmd_ready <= 1'b1;
          end else if (setup_cnt == SETUP_LAST) begin
            state <= ACCEL;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end

        default: begin
          if (step_start) begin
            pos <= dir_out ? pos + 32'sd1 : pos - 32'sd1;
          end
          abort_lat <= (state == DECEL) ? 1'b0 : abort_now;
          if (step_end) begin
            abort_lat <= 1'b0;
            if (last_step) begin
              remaining <= '0;
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              en_n_out  <= 1'b1;
              cmd_ready <= 1'b1;
            end else if (state == ACCEL) begin
              accel_cnt <= acc_inc;
              remaining <= rem_next;
              if (rem_next <= acc_inc) begin
                state <= DECEL;
              end else begin
                period <= per_dn;
                if (per_dn == MIN_V) state <= CRUISE;
              end
            end else if (state == CRUISE) begin
              remaining <= rem_next;
              if (rem_next <= accel_cnt) begin
                state  <= DECEL;
                period <= per_up;
              end
            end else begin
              remaining <= rem_dec;
              period    <= per_up;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Self-checking bench for stepper_ramp_ctrl with a step-level reference model.
module tb_stepper_ramp_ctrl;

  localparam int T_START = 1000;
  localparam int T_MIN   = 500;
  localparam int T_DELTA = 100;
  localparam int T_PULSE = 10;
  localparam int T_SETUP = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_dir = 1'b0;
  logic [23:0]        cmd_steps = '0;
  logic               abort = 1'b0;
  logic               step_out;
  logic               dir_out;
  logic               en_n_out;
  logic               busy;
  logic               done;
  logic signed [31:0] pos;

  always #5 clk = ~clk;

  stepper_ramp_ctrl #(
    .STEP_W       (24),
    .PERIOD_W     (16),
    .START_PERIOD (T_START),
    .MIN_PERIOD   (T_MIN),
    .RAMP_DELTA   (T_DELTA),
    .PULSE_W      (T_PULSE),
    .DIR_SETUP    (T_SETUP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .step_out  (step_out),
    .dir_out   (dir_out),
    .en_n_out  (en_n_out),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (step granularity) ----------------
  typedef enum {PH_UP, PH_FLAT, PH_DOWN} phase_t;
  bit     m_moving = 0;
  bit     m_stepping = 0;
  bit     m_pend = 0;
  int     m_setup_left, m_t, m_per, m_rem, m_ac;
  phase_t m_ph;
  logic        e_step = 0, e_dir = 0, e_en_n = 1, e_busy = 0, e_done = 0, e_ready = 1;
  logic [31:0] e_pos = '0;

  task automatic finish_move();
    m_moving = 0; m_stepping = 0; m_pend = 0;
    e_step = 0; e_done = 1; e_busy = 0; e_en_n = 1; e_ready = 1;
  endtask

  task automatic start_step();
    m_t = 0; e_step = 1;
    e_pos = e_dir ? e_pos + 32'd1 : e_pos - 32'd1;
  endtask

  task automatic model_tick(input bit r, input bit v, input bit d, input logic [23:0] n, input bit ab);
    e_done = 0;
    if (r) begin
      m_moving = 0; m_stepping = 0; m_pend = 0;
      e_step = 0; e_dir = 0; e_en_n = 1; e_busy = 0; e_ready = 1; e_pos = '0;
      return;
    end
    if (!m_moving) begin
      if (v) begin
        e_dir = d;
        if (n == 0) e_done = 1;
        else begin
          m_moving = 1; m_stepping = 0; m_setup_left = T_SETUP;
          m_rem = int'(n); m_ac = 0; m_per = T_START; m_ph = PH_UP; m_pend = 0;
          e_en_n = 0; e_busy = 1; e_ready = 0;
        end
      end
      return;
    end
    if (!m_stepping) begin
      if (m_setup_left > 0) begin
        if (ab) finish_move();
        else m_setup_left--;
        return;
      end
      m_stepping = 1;
      start_step();
      m_pend = ab;
      return;
    end
    if (m_ph == PH_DOWN) m_pend = 0;
    else m_pend = m_pend | ab;
    if (m_t != m_per - 1) begin
      m_t++;
      e_step = (m_t < T_PULSE);
      return;
    end
    m_rem--;
    if (m_rem == 0) begin
      finish_move();
      return;
    end
    case (m_ph)
      PH_UP: begin
        m_ac++;
        if (m_pend && m_rem > m_ac) m_rem = m_ac;
        if (m_rem <= m_ac) m_ph = PH_DOWN;
        else begin
          m_per = (m_per - T_DELTA < T_MIN) ? T_MIN : m_per - T_DELTA;
          if (m_per == T_MIN) m_ph = PH_FLAT;
        end
      end
      PH_FLAT: begin
        if (m_pend && m_rem > m_ac) m_rem = m_ac;
        if (m_rem <= m_ac) begin
          m_ph = PH_DOWN;
          m_per = (m_per + T_DELTA > T_START) ? T_START : m_per + T_DELTA;
        end
      end
      default: m_per = (m_per + T_DELTA > T_START) ? T_START : m_per + T_DELTA;
    endcase
    m_pend = 0;
    start_step();
  endtask

  always @(posedge clk) model_tick(rst, cmd_valid, cmd_dir, cmd_steps, abort);

  // ---------------- per-cycle compare + period observation ----------------
  bit   chk_en = 0;
  bit   prev_step = 0;
  bit   have_rise = 0;
  int   ncyc = 0;
  int   last_rise = 0;
  int   n_rise = 0;
  int   obs_per[$];
  int   exp_per[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("step_out", 32'(step_out), 32'(e_step));
      chk("dir_out", 32'(dir_out), 32'(e_dir));
      chk("en_n_out", 32'(en_n_out), 32'(e_en_n));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("pos", pos, e_pos);
      if (rst) have_rise = 0;
      if (step_out === 1'b1 && !prev_step) begin
        if (have_rise) obs_per.push_back(ncyc - last_rise);
        last_rise = ncyc; have_rise = 1; n_rise++;
      end
      if (done === 1'b1 && have_rise) begin
        obs_per.push_back(ncyc - last_rise);
        have_rise = 0;
      end
      prev_step = (step_out === 1'b1);
      ncyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit d, input int n);
    cmd_dir = d; cmd_steps = 24'(n); cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin cyc(); k++; end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: no done within %0d cycles, want done", name, budget);
    end
  endtask

  task automatic chk_periods(input string name);
    chk({name, "_nsteps"}, 32'(obs_per.size()), 32'(exp_per.size()));
    for (int i = 0; i < exp_per.size() && i < obs_per.size(); i++)
      chk(name, 32'(obs_per[i]), 32'(exp_per[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base;
    int k;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_en_n", 32'(en_n_out), 32'd1);
    chk("rst_pos", pos, 32'd0);
    rst = 1'b0;
    cyc();

    // 20 steps forward: full trapezoid
    obs_per.delete(); exp_per.delete();
    for (int p = 1000; p > 500; p -= 100) exp_per.push_back(p);
    repeat (10) exp_per.push_back(500);
    for (int p = 600; p <= 1000; p += 100) exp_per.push_back(p);
    issue(1'b1, 20);
    wait_done(20000, "fwd20_done");
    cyc();
    chk_periods("fwd20_period");
    chk("fwd20_pos", pos, 32'd20);

    // 10 steps reverse: triangle, never reaches cruise
    do_reset();
    obs_per.delete(); exp_per.delete();
    for (int p = 1000; p >= 600; p -= 100) exp_per.push_back(p);
    for (int p = 600; p <= 1000; p += 100) exp_per.push_back(p);
    issue(1'b0, 10);
    wait_done(20000, "rev10_done");
    cyc();
    chk_periods("rev10_period");
    chk("rev10_pos", pos, 32'hFFFF_FFF6);

    // zero-step command
    issue(1'b1, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_en_n", 32'(en_n_out), 32'd1);
    chk("zero_step", 32'(step_out), 32'd0);
    cyc();
    chk("zero_done_clear", 32'(done), 32'd0);

    // abort during step 8 of 100
    do_reset();
    obs_per.delete(); exp_per.delete();
    for (int p = 1000; p >= 600; p -= 100) exp_per.push_back(p);
    repeat (3) exp_per.push_back(500);
    for (int p = 600; p <= 1000; p += 100) exp_per.push_back(p);
    base = n_rise;
    issue(1'b1, 100);
    k = 0;
    while (n_rise < base + 8 && k < 20000) begin cyc(); k++; end
    chk("abort_reach_step8", 32'(n_rise - base >= 8), 32'd1);
    repeat (50) cyc();
    abort = 1'b1; cyc(); abort = 1'b0;
    wait_done(20000, "abort_done");
    cyc();
    chk_periods("abort_period");
    chk("abort_pos", pos, 32'd13);

    // reset in the middle of a STEP pulse
    issue(1'b1, 5);
    k = 0;
    while (step_out !== 1'b1 && k < 100) begin cyc(); k++; end
    chk("rst_mid_seen_pulse", 32'(step_out), 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_mid_step", 32'(step_out), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_pos", pos, 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    cyc();

    // cmd_valid held through a move: ignored while busy, re-accepted at done
    cmd_dir = 1'b1; cmd_steps = 24'd3; cmd_valid = 1'b1;
    cyc();
    wait_done(20000, "held_done1");
    cyc();
    cmd_valid = 1'b0;
    chk("held_reaccept_busy", 32'(busy), 32'd1);
    wait_done(20000, "held_done2");
    cyc();
    chk("held_pos", pos, 32'd6);

    // randomized moves with sporadic aborts and stray commands
    for (int m = 0; m < 4; m++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
      k = 0;
      while (busy === 1'b1 && k < 12000) begin
        abort = ($urandom_range(0, 399) == 0);
        cmd_valid = ($urandom_range(0, 199) == 0);
        cmd_steps = 24'($urandom_range(1, 6));
        cmd_dir = 1'($urandom_range(0, 1));
        cyc(); k++;
      end
      abort = 1'b0; cmd_valid = 1'b0;
      cyc();
      k = 0;
      while (busy === 1'b1 && k < 12000) begin cyc(); k++; end
      chk("rand_idle", 32'(busy), 32'd0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
